// File: rtl/dpram_readback_checker.sv
// dpram_readback_checker
// Takes over the read side of both ports of a dual-port block RAM after it
// has been filled with the ramp pattern mem[a] = a+1. It scans port A over
// 0..HALF-1 and port B over HALF..2*HALF-1 in parallel, then reports
// pass/fail, an error count and (optionally) the first failing location.
//
// Optional feature macro: CHK_ERR_LOG_EN
//   defined   : first_err_addr / first_err_data capture the first mismatch
//   undefined : capture registers not built, both outputs tied to 0
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             one-cycle scan request, sampled only in IDLE
//   douta, doutb      RAM read data, ports A and B
//   addra, addrb      registered read addresses, ports A and B
//   wea, web          write enables, constant 0
//   busy              high from the start edge until the done edge
//   done              one-cycle pulse at the end of a scan
//   pass              last scan finished with err_cnt == 0
//   err_cnt           mismatches seen in the current or last scan
//   first_err_addr    address of the first mismatch
//   first_err_data    data returned at the first mismatch
module dpram_readback_checker #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 10,
  parameter int unsigned HALF   = 512,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] douta,
  input  logic [DW-1:0] doutb,
  output logic [AW-1:0] addra,
  output logic [AW-1:0] addrb,
  output logic          wea,
  output logic          web,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data
);

  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned CW  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_go;
  logic          w_issue_last;
  logic          w_drain_end;
  logic          w_issue_adv;

  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_drain_cnt;
  logic [AW-1:0] r_addra;
  logic [AW-1:0] r_addrb;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [AW:0]   r_err_cnt;

  // Outstanding-read tags: stage 0 is loaded with the index registered on
  // the same edge; the last stage lines up with returning RAM data.
  logic [RD_LAT-1:0] r_tag_vld;
  logic [AW-1:0]     r_tag_idx [RD_LAT];

  logic [AW:0]   w_addr_a;
  logic [AW:0]   w_addr_b;
  logic [DW-1:0] w_exp_a;
  logic [DW-1:0] w_exp_b;
  logic          w_cmp;
  logic          w_mis_a;
  logic          w_mis_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_go         = 1'b0;
    w_issue_last = 1'b0;
    w_drain_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_go        = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_idx == AW'(HALF - 1)) begin
          w_state_nxt  = S_DRAIN;
          w_issue_last = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == CW'(RD_LAT - 1)) begin
          w_state_nxt = S_DONE;
          w_drain_end = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_issue_adv = (r_state == S_ISSUE) && !w_issue_last;

  // Expected ramp values for the tag leaving the pipeline
  assign w_cmp    = r_tag_vld[RD_LAT-1];
  assign w_addr_a = {1'b0, r_tag_idx[RD_LAT-1]};
  assign w_addr_b = AW1'(HALF) + {1'b0, r_tag_idx[RD_LAT-1]};
  assign w_exp_a  = DW'(w_addr_a + AW1'(1));
  assign w_exp_b  = DW'(w_addr_b + AW1'(1));
  assign w_mis_a  = w_cmp && (douta !== w_exp_a);
  assign w_mis_b  = w_cmp && (doutb !== w_exp_b);

  // Address generation, drain counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_addra     <= '0;
      r_addrb     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= w_drain_end;
      if (w_go) begin
        r_idx   <= '0;
        r_addra <= '0;
        r_addrb <= AW'(HALF);
        r_busy  <= 1'b1;
        r_pass  <= 1'b0;
      end else if (w_issue_adv) begin
        r_idx   <= r_idx + AW'(1);
        r_addra <= r_addra + AW'(1);
        r_addrb <= r_addrb + AW'(1);
      end
      if (w_issue_last) begin
        r_drain_cnt <= '0;
      end else if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + CW'(1);
      end
      // All compares have retired before this edge, so err_cnt is final
      if (w_drain_end) begin
        r_busy <= 1'b0;
        r_pass <= (r_err_cnt == '0);
      end
    end
  end

  // Tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag_idx[i] <= '0;
    end else begin
      r_tag_vld[0] <= w_go || w_issue_adv;
      r_tag_idx[0] <= w_go ? '0 : (r_idx + AW'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Error counter: each mismatching port adds one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_go) begin
      r_err_cnt <= '0;
    end else if (w_cmp) begin
      r_err_cnt <= r_err_cnt + AW1'(w_mis_a) + AW1'(w_mis_b);
    end
  end

`ifdef CHK_ERR_LOG_EN
  logic [AW-1:0] r_first_err_addr;
  logic [DW-1:0] r_first_err_data;

  // First mismatch of the scan only; port A wins a same-edge tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if (w_go) begin
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if ((r_err_cnt == '0) && (w_mis_a || w_mis_b)) begin
      if (w_mis_a) begin
        r_first_err_addr <= AW'(w_addr_a);
        r_first_err_data <= douta;
      end else begin
        r_first_err_addr <= AW'(w_addr_b);
        r_first_err_data <= doutb;
      end
    end
  end

  assign first_err_addr = r_first_err_addr;
  assign first_err_data = r_first_err_data;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

  assign addra   = r_addra;
  assign addrb   = r_addrb;
  assign wea     = 1'b0;
  assign web     = 1'b0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_dpram_readback_checker.sv
// Bench for dpram_readback_checker: one instance at RD_LAT=1 and one at
// RD_LAT=3 share a RAM model preloaded with mem[a] = a+1.
module tb_dpram_readback_checker;

  logic        clk;
  logic        rst_n;
  logic        start_drv;
  logic        sel3;
  logic [15:0] mem [1024];

  logic        start1, start3;
  logic [15:0] douta1, doutb1, douta3, doutb3;
  logic [9:0]  addra1, addrb1, addra3, addrb3;
  logic        wea1, web1, wea3, web3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [10:0] err1, err3;
  logic [9:0]  fea1, fea3;
  logic [15:0] fed1, fed3;

  logic [15:0] pa1, pa2, pb1, pb2;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start1 = start_drv & ~sel3;
  assign start3 = start_drv & sel3;

  // Latency-1 RAM: data for an address registered on edge k is sampled on k+1
  assign douta1 = mem[addra1];
  assign doutb1 = mem[addrb1];

  // Latency-3 RAM: two extra register stages
  always @(posedge clk) begin
    pa1 <= mem[addra3];
    pa2 <= pa1;
    pb1 <= mem[addrb3];
    pb2 <= pb1;
  end
  assign douta3 = pa2;
  assign doutb3 = pb2;

  dpram_readback_checker #(.DW(16), .AW(10), .HALF(512), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .douta(douta1), .doutb(doutb1),
    .addra(addra1), .addrb(addrb1), .wea(wea1), .web(web1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(fea1),
    .first_err_data(fed1));

  dpram_readback_checker #(.DW(16), .AW(10), .HALF(512), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .douta(douta3), .doutb(doutb3),
    .addra(addra3), .addrb(addrb3), .wea(wea3), .web(web3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(err3), .first_err_addr(fea3),
    .first_err_data(fed3));

  // Selected instance view
  logic        m_busy, m_done;
  logic [9:0]  m_addra, m_addrb;
  assign m_busy  = sel3 ? busy3 : busy1;
  assign m_done  = sel3 ? done3 : done1;
  assign m_addra = sel3 ? addra3 : addra1;
  assign m_addrb = sel3 ? addrb3 : addrb1;

  task automatic load_ramp();
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a + 1);
  endtask

  // Drives one scan; reports edge of first done, number of done pulses and
  // edge-0 observations. A reset edge aborts the scan with rst_n held low.
  task automatic run_scan(input int extra_start, input int rst_edge,
                          output int done_edge, output int done_cnt,
                          output logic busy0, output logic [9:0] a0,
                          output logic [9:0] b0);
    bit stop;
    done_edge = -1;
    done_cnt  = 0;
    stop      = 1'b0;
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    start_drv = 1'b0;
    busy0 = m_busy;
    a0    = m_addra;
    b0    = m_addrb;
    for (int n = 1; n <= 1200 && !stop; n++) begin
      @(negedge clk);
      start_drv = (n == extra_start);
      @(posedge clk);
      #1;
      start_drv = 1'b0;
      if (n == rst_edge) begin
        rst_n = 1'b0;
        #1;
        stop = 1'b1;
      end else begin
        if (m_done) begin
          done_cnt++;
          if (done_edge < 0) done_edge = n;
        end
        if (done_edge >= 0 && n >= done_edge + 4) stop = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_drv = 1'b0;
    sel3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({addra1, addrb1, wea1, web1, busy1, done1, pass1, err1, fea1, fed1} !== '0) begin
      bad++;
      $display("FAIL reset_dut1 got addra=%0d addrb=%0d busy=%0b done=%0b pass=%0b err=%0d fea=%0d fed=%0h want all 0",
               addra1, addrb1, busy1, done1, pass1, err1, fea1, fed1);
    end
    total++;
    if ({addra3, addrb3, wea3, web3, busy3, done3, pass3, err3, fea3, fed3} !== '0) begin
      bad++;
      $display("FAIL reset_dut3 got addra=%0d addrb=%0d busy=%0b done=%0b pass=%0b err=%0d want all 0",
               addra3, addrb3, busy3, done3, pass3, err3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_scan();
    int de, dc;
    logic b0;
    logic [9:0] a0, bb0;
    sel3 = 1'b0;
    load_ramp();
    run_scan(-1, -1, de, dc, b0, a0, bb0);
    total++;
    if (b0 !== 1'b1 || a0 !== 10'd0 || bb0 !== 10'd512) begin
      bad++;
      $display("FAIL clean_edge0 got busy=%0b addra=%0d addrb=%0d want 1 0 512", b0, a0, bb0);
    end
    total++;
    if (de != 513 || dc != 1) begin
      bad++;
      $display("FAIL clean_done got edge=%0d pulses=%0d want 513 1", de, dc);
    end
    total++;
    if (pass1 !== 1'b1 || err1 !== 11'd0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL clean_result got pass=%0b err=%0d busy=%0b want 1 0 0", pass1, err1, busy1);
    end
    total++;
    if (addra1 !== 10'd511 || addrb1 !== 10'd1023 || wea1 !== 1'b0 || web1 !== 1'b0) begin
      bad++;
      $display("FAIL clean_final_addr got addra=%0d addrb=%0d want 511 1023", addra1, addrb1);
    end
  endtask

  task automatic test_single_error();
    int de, dc;
    logic b0;
    logic [9:0] a0, bb0, exp_a;
    logic [15:0] exp_d;
    sel3 = 1'b0;
    load_ramp();
    mem[5] = 16'hDEAD;
`ifdef CHK_ERR_LOG_EN
    exp_a = 10'd5;
    exp_d = 16'hDEAD;
`else
    exp_a = 10'd0;
    exp_d = 16'h0;
`endif
    run_scan(-1, -1, de, dc, b0, a0, bb0);
    total++;
    if (de != 513 || err1 !== 11'd1 || pass1 !== 1'b0) begin
      bad++;
      $display("FAIL single_err got edge=%0d err=%0d pass=%0b want 513 1 0", de, err1, pass1);
    end
    total++;
    if (fea1 !== exp_a || fed1 !== exp_d) begin
      bad++;
      $display("FAIL single_first got addr=%0d data=%0h want %0d %0h", fea1, fed1, exp_a, exp_d);
    end
    load_ramp();
  endtask

  task automatic test_dual_error();
    int de, dc;
    logic b0;
    logic [9:0] a0, bb0, exp_a;
    logic [15:0] exp_d;
    sel3 = 1'b0;
    load_ramp();
    mem[7]   = 16'hBEEF;
    mem[519] = 16'h1234;
`ifdef CHK_ERR_LOG_EN
    exp_a = 10'd7;
    exp_d = 16'hBEEF;
`else
    exp_a = 10'd0;
    exp_d = 16'h0;
`endif
    run_scan(-1, -1, de, dc, b0, a0, bb0);
    total++;
    if (err1 !== 11'd2 || pass1 !== 1'b0) begin
      bad++;
      $display("FAIL dual_err got err=%0d pass=%0b want 2 0", err1, pass1);
    end
    total++;
    if (fea1 !== exp_a || fed1 !== exp_d) begin
      bad++;
      $display("FAIL dual_first got addr=%0d data=%0h want %0d %0h", fea1, fed1, exp_a, exp_d);
    end
    load_ramp();
  endtask

  task automatic test_restart_ignored();
    int de, dc;
    logic b0;
    logic [9:0] a0, bb0;
    sel3 = 1'b0;
    load_ramp();
    mem[600] = 16'h0000;
    run_scan(200, -1, de, dc, b0, a0, bb0);
    total++;
    if (de != 513 || dc != 1) begin
      bad++;
      $display("FAIL restart_done got edge=%0d pulses=%0d want 513 1", de, dc);
    end
    total++;
    if (err1 !== 11'd1 || pass1 !== 1'b0 || addrb1 !== 10'd1023) begin
      bad++;
      $display("FAIL restart_result got err=%0d pass=%0b addrb=%0d want 1 0 1023", err1, pass1, addrb1);
    end
    load_ramp();
  endtask

  task automatic test_reset_mid_scan();
    int de, dc;
    logic b0;
    logic [9:0] a0, bb0;
    sel3 = 1'b0;
    load_ramp();
    mem[3] = 16'hFFFF;
    run_scan(-1, 100, de, dc, b0, a0, bb0);
    total++;
    if ({addra1, addrb1, busy1, done1, pass1, err1, fea1, fed1} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got addra=%0d addrb=%0d busy=%0b err=%0d fea=%0d want all 0",
               addra1, addrb1, busy1, err1, fea1);
    end
    load_ramp();
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(-1, -1, de, dc, b0, a0, bb0);
    total++;
    if (de != 513 || dc != 1 || pass1 !== 1'b1 || err1 !== 11'd0) begin
      bad++;
      $display("FAIL midreset_rescan got edge=%0d pulses=%0d pass=%0b err=%0d want 513 1 1 0",
               de, dc, pass1, err1);
    end
  endtask

  task automatic test_lat3();
    int de, dc;
    logic b0;
    logic [9:0] a0, bb0;
    sel3 = 1'b1;
    load_ramp();
    run_scan(-1, -1, de, dc, b0, a0, bb0);
    total++;
    if (de != 515 || dc != 1) begin
      bad++;
      $display("FAIL lat3_done got edge=%0d pulses=%0d want 515 1", de, dc);
    end
    total++;
    if (pass3 !== 1'b1 || err3 !== 11'd0 || addra3 !== 10'd511 || addrb3 !== 10'd1023) begin
      bad++;
      $display("FAIL lat3_result got pass=%0b err=%0d addra=%0d addrb=%0d want 1 0 511 1023",
               pass3, err3, addra3, addrb3);
    end
    // Last port-B word corrupted: catches a pipeline that drops the final tag
    mem[1023] = 16'h0BAD;
    run_scan(-1, -1, de, dc, b0, a0, bb0);
    total++;
    if (err3 !== 11'd1 || pass3 !== 1'b0) begin
      bad++;
      $display("FAIL lat3_last_word got err=%0d pass=%0b want 1 0", err3, pass3);
    end
    load_ramp();
    sel3 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    load_ramp();
    test_reset();
    test_clean_scan();
    test_single_error();
    test_dual_error();
    test_restart_ignored();
    test_reset_mid_scan();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
